background_tile_array_mover: RTL and testbench

Parametrised, multi-channel generalisation of the single background-tile mover. It holds N_TILES fixed-point tile positions and moves them on both axes once per frame with a shared signed velocity. Positions wrap toroidally at the configurable frame bounds. A time-multiplexed scan FSM updates one channel per clock, so only one adder pair is needed. The block sits between the frame timing generator and the background tile drawers.

---
 rtl/background_tile_array_mover_if.sv | 55 +++++
 rtl/background_tile_array_mover.sv | 143 ++++++++++++++
 tb/tb_background_tile_array_mover.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/background_tile_array_mover_if.sv
// Bus between frame timing, the tile-array mover and the tile drawers.
// PARALLAX_EN adds the per-channel parallaxShift field.
interface background_tile_array_mover_if #(
   parameter int N_TILES = 4,
   parameter int POS_W   = 11,
   parameter int SPEED_W = 16
);
   logic                       startOfFrame;
   logic signed [SPEED_W-1:0]  speedX;
   logic signed [SPEED_W-1:0]  speedY;
   logic [N_TILES*POS_W-1:0]   initialX;
   logic [N_TILES*POS_W-1:0]   initialY;
   logic [N_TILES-1:0]         load;
   logic [N_TILES-1:0]         visible;
   logic [N_TILES*POS_W-1:0]   topLeftX;
   logic [N_TILES*POS_W-1:0]   topLeftY;
   logic [N_TILES-1:0]         wrapPulse;
   logic                       busy;
   logic                       frameDone;
   logic                       overrun;

`ifdef PARALLAX_EN
   logic [N_TILES*3-1:0]       parallaxShift;

   modport master (
      output startOfFrame, speedX, speedY,
      output initialX, initialY, load, visible,
      output parallaxShift,
      input  topLeftX, topLeftY, wrapPulse,
      input  busy, frameDone, overrun
   );

   modport slave (
      input  startOfFrame, speedX, speedY,
      input  initialX, initialY, load, visible,
      input  parallaxShift,
      output topLeftX, topLeftY, wrapPulse,
      output busy, frameDone, overrun
   );
`else
   modport master (
      output startOfFrame, speedX, speedY,
      output initialX, initialY, load, visible,
      input  topLeftX, topLeftY, wrapPulse,
      input  busy, frameDone, overrun
   );

   modport slave (
      input  startOfFrame, speedX, speedY,
      input  initialX, initialY, load, visible,
      output topLeftX, topLeftY, wrapPulse,
      output busy, frameDone, overrun
   );
`endif
endinterface

// File: rtl/background_tile_array_mover.sv
// N-channel toroidal tile mover; one channel updated per clock by a scan FSM.
// Optional macro PARALLAX_EN: per-channel speed >>> parallaxShift.
module background_tile_array_mover #(
   parameter int N_TILES   = 4,
   parameter int POS_W     = 11,
   parameter int FRAC_BITS = 6,
   parameter int SPEED_W   = 16,
   parameter int X_MAX     = 639,
   parameter int Y_MAX     = 479
) (
   input logic clk,
   input logic reset,
   background_tile_array_mover_if.slave bus
);

   localparam int ACC_W  = POS_W + FRAC_BITS + 1;
   localparam int MAX_W  = (ACC_W > SPEED_W) ? ACC_W : SPEED_W;
   localparam int CALC_W = MAX_W + 2;
   localparam int IDX_W  = (N_TILES > 1) ? $clog2(N_TILES) : 1;

   localparam logic signed [CALC_W-1:0] SPAN_X =
      CALC_W'((X_MAX + 1) << FRAC_BITS);
   localparam logic signed [CALC_W-1:0] SPAN_Y =
      CALC_W'((Y_MAX + 1) << FRAC_BITS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TILES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [IDX_W-1:0]          idx;
   logic signed [SPEED_W-1:0] spdX, spdY;
   logic signed [ACC_W-1:0]   accX [N_TILES];
   logic signed [ACC_W-1:0]   accY [N_TILES];
   logic [N_TILES-1:0]        wrap_q;
   logic                      done_q;
   logic                      overrun_q;

   logic signed [SPEED_W-1:0] effX, effY;
   logic signed [CALC_W-1:0]  sumX, sumY;
   logic signed [CALC_W-1:0]  nxX, nxY;
   logic                      wrX, wrY;
   logic                      doMove;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.startOfFrame) state_nx = SCAN;
         SCAN:    if (idx == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Single shared adder pair, steered by the scan index.
   always_comb begin
      effX = spdX;
      effY = spdY;
`ifdef PARALLAX_EN
      effX = spdX >>> bus.parallaxShift[idx*3 +: 3];
      effY = spdY >>> bus.parallaxShift[idx*3 +: 3];
`endif
      sumX = CALC_W'(accX[idx]) + CALC_W'(effX);
      sumY = CALC_W'(accY[idx]) + CALC_W'(effY);
      nxX  = sumX;
      nxY  = sumY;
      wrX  = 1'b0;
      wrY  = 1'b0;
      if (sumX >= SPAN_X) begin
         nxX = sumX - SPAN_X;
         wrX = 1'b1;
      end else if (sumX[CALC_W-1]) begin
         nxX = sumX + SPAN_X;
         wrX = 1'b1;
      end
      if (sumY >= SPAN_Y) begin
         nxY = sumY - SPAN_Y;
         wrY = 1'b1;
      end else if (sumY[CALC_W-1]) begin
         nxY = sumY + SPAN_Y;
         wrY = 1'b1;
      end
      doMove = (state == SCAN) && bus.visible[idx] && !bus.load[idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         spdX      <= '0;
         spdY      <= '0;
         wrap_q    <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < N_TILES; i++) begin
            accX[i] <= '0;
            accY[i] <= '0;
         end
      end else begin
         state  <= state_nx;
         done_q <= (state == DONE);
         wrap_q <= '0;
         if (state == IDLE && bus.startOfFrame) begin
            spdX <= bus.speedX;
            spdY <= bus.speedY;
            idx  <= '0;
         end else if (state == SCAN) begin
            idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
         end
         if (state != IDLE && bus.startOfFrame)
            overrun_q <= 1'b1;
         if (doMove) begin
            accX[idx]   <= ACC_W'(nxX);
            accY[idx]   <= ACC_W'(nxY);
            wrap_q[idx] <= wrX | wrY;
         end
         // Loads come last so they override a same-cycle move.
         for (int i = 0; i < N_TILES; i++) begin
            if (bus.load[i]) begin
               accX[i] <= ACC_W'($signed(bus.initialX[i*POS_W +: POS_W]))
                          <<< FRAC_BITS;
               accY[i] <= ACC_W'($signed(bus.initialY[i*POS_W +: POS_W]))
                          <<< FRAC_BITS;
            end
         end
      end
   end

   for (genvar g = 0; g < N_TILES; g++) begin : g_out
      assign bus.topLeftX[g*POS_W +: POS_W] = POS_W'(accX[g] >>> FRAC_BITS);
      assign bus.topLeftY[g*POS_W +: POS_W] = POS_W'(accY[g] >>> FRAC_BITS);
   end

   assign bus.wrapPulse = wrap_q;
   assign bus.busy      = (state == SCAN);
   assign bus.frameDone = done_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_background_tile_array_mover.sv
// Bench for background_tile_array_mover: vector table, corner sequences,
// and random frames against a modulo-arithmetic reference model.
module tb_background_tile_array_mover;

   localparam int N   = 4;
   localparam int PW  = 11;
   localparam int FB  = 6;
   localparam int SW  = 16;
   localparam int SPX = 640 * 64;
   localparam int SPY = 480 * 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   background_tile_array_mover_if #(
      .N_TILES(N), .POS_W(PW), .SPEED_W(SW)
   ) bus ();

   background_tile_array_mover #(
      .N_TILES(N), .POS_W(PW), .FRAC_BITS(FB), .SPEED_W(SW),
      .X_MAX(639), .Y_MAX(479)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   int ix [N];
   int iy [N];
   logic [N-1:0] wmask;
   int wcyc;
   int wedge [N];

   typedef struct {
      int ch; int x; int y; int sx; int sy;
      bit vis; bit ewrap; int ex; int ey;
   } vec_t;
   vec_t vt [9];

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm,
                  $signed(act), $signed(exp));
      end
   endtask

   function automatic logic signed [PW-1:0] tx(input int c);
      return bus.topLeftX[c*PW +: PW];
   endfunction

   function automatic logic signed [PW-1:0] ty(input int c);
      return bus.topLeftY[c*PW +: PW];
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      bus.load = '0;
      bus.startOfFrame = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic do_load(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) begin
         bus.initialX[i*PW +: PW] = PW'(ix[i]);
         bus.initialY[i*PW +: PW] = PW'(iy[i]);
      end
      bus.load = m;
      @(posedge clk); #1;
      bus.load = '0;
   endtask

   // One frame; optional load of channel lch in its scan cycle and an
   // extra startOfFrame in the cycle after edge ov_edge.
   task automatic run_frame(input int sx, input int sy, input int lch,
                            input int lx, input int ly, input int ov_edge);
      int busyc, fdc, fde;
      busyc = 0; fdc = 0; fde = -1; wmask = '0; wcyc = 0;
      for (int i = 0; i < N; i++) wedge[i] = -1;
      bus.speedX = SW'(sx);
      bus.speedY = SW'(sy);
      bus.startOfFrame = 1'b1;
      for (int e = 0; e <= N + 2; e++) begin
         @(posedge clk); #1;
         if (e == 0) begin
            bus.speedX = ~bus.speedX;
            bus.speedY = SW'(sy + 12345);
         end
         if (bus.busy) busyc++;
         if (bus.frameDone) begin fdc++; fde = e; end
         for (int i = 0; i < N; i++)
            if (bus.wrapPulse[i]) begin
               wmask[i] = 1'b1; wcyc++; wedge[i] = e;
            end
         if (e == lch) begin
            bus.initialX[lch*PW +: PW] = PW'(lx);
            bus.initialY[lch*PW +: PW] = PW'(ly);
            bus.load[lch] = 1'b1;
         end else begin
            bus.load = '0;
         end
         bus.startOfFrame = (e == ov_edge);
      end
      bus.startOfFrame = 1'b0;
      bus.load = '0;
      check("busy_cycles", busyc, N);
      check("frame_done_count", fdc, 1);
      check("frame_done_edge", fde, N + 1);
      check("wrap_one_cycle", wcyc, $countones(wmask));
   endtask

   int mx [N];
   int my [N];
   logic [N*PW-1:0] ex, ey;
   logic [N-1:0] em, vis, lm;
   int sx, sy, n;

   initial begin
      vt[0] = '{0, 100, 200,   0,  64, 1, 0, 100, 201};
      vt[1] = '{1,  10, 479,   0,  64, 1, 1,  10,   0};
      vt[2] = '{2,   5,   0,   0, -32, 1, 1,   5, 479};
      vt[3] = '{3, 639,   7,  64,   0, 1, 1,   0,   7};
      vt[4] = '{0,   0,   0, -64, -64, 1, 1, 639, 479};
      vt[5] = '{1,  -5,  10,   0,   0, 1, 1, 635,  10};
      vt[6] = '{2, 300, 100,  64,  64, 0, 0, 300, 100};
      vt[7] = '{3, 638, 478,  63, 127, 1, 0, 638, 479};
      vt[8] = '{0,   0, 240,  -1,   0, 1, 1, 639, 240};

      reset = 1'b1;
      bus.startOfFrame = 1'b0;
      bus.speedX = '0;
      bus.speedY = '0;
      bus.initialX = '0;
      bus.initialY = '0;
      bus.load = '0;
      bus.visible = '1;
`ifdef PARALLAX_EN
      bus.parallaxShift = '0;
`endif
      #1;
      check("rst_x", bus.topLeftX, 0);
      check("rst_y", bus.topLeftY, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.frameDone, 0);
      check("rst_overrun", bus.overrun, 0);
      check("rst_wrap", bus.wrapPulse, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int v = 0; v < 9; v++) begin
         do_reset();
         for (int i = 0; i < N; i++) begin ix[i] = 320; iy[i] = 240; end
         ix[vt[v].ch] = vt[v].x;
         iy[vt[v].ch] = vt[v].y;
         do_load('1);
         bus.visible = '1;
         if (!vt[v].vis) bus.visible[vt[v].ch] = 1'b0;
         run_frame(vt[v].sx, vt[v].sy, -1, 0, 0, -1);
         check($sformatf("vec%0d_x", v), tx(vt[v].ch), vt[v].ex);
         check($sformatf("vec%0d_y", v), ty(vt[v].ch), vt[v].ey);
         em = '0;
         em[vt[v].ch] = vt[v].ewrap;
         check($sformatf("vec%0d_wrap", v), wmask, em);
         if (vt[v].ewrap)
            check($sformatf("vec%0d_wrap_edge", v), wedge[vt[v].ch],
                  vt[v].ch + 1);
      end

      // Hidden channel holds across three frames.
      do_reset();
      for (int i = 0; i < N; i++) begin ix[i] = 320; iy[i] = 240; end
      do_load('1);
      bus.visible = 4'b1110;
      for (int f = 0; f < 3; f++) run_frame(64, -64, -1, 0, 0, -1);
      check("hold_x0", tx(0), 320);
      check("hold_y0", ty(0), 240);
      check("move_x1", tx(1), 323);
      check("move_y1", ty(1), 237);

      // Load in channel 2's scan cycle beats the move.
      bus.visible = '1;
      do_load('1);
      run_frame(0, 64, 2, 77, 50, -1);
      check("ldpri_x2", tx(2), 77);
      check("ldpri_y2", ty(2), 50);
      check("ldpri_wrap2", wmask[2], 0);
      check("ldpri_y1", ty(1), 241);

      // Overrun during SCAN, then during DONE.
      check("ovr_before", bus.overrun, 0);
      run_frame(0, 0, -1, 0, 0, 1);
      check("ovr_scan", bus.overrun, 1);
      do_reset();
      check("ovr_cleared", bus.overrun, 0);
      run_frame(0, 0, -1, 0, 0, N);
      check("ovr_done", bus.overrun, 1);

      // Asynchronous reset mid-scan.
      for (int i = 0; i < N; i++) begin ix[i] = 100 + i; iy[i] = 50; end
      do_load('1);
      bus.speedX = 16'sd64;
      bus.speedY = 16'sd64;
      bus.startOfFrame = 1'b1;
      @(posedge clk); #1;
      bus.startOfFrame = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("arst_x", bus.topLeftX, 0);
      check("arst_y", bus.topLeftY, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_overrun", bus.overrun, 0);
      check("arst_wrap", bus.wrapPulse, 0);
      check("arst_done", bus.frameDone, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      run_frame(64, 64, -1, 0, 0, -1);
      check("post_rst_x", bus.topLeftX, {N{PW'(1)}});
      check("post_rst_y", bus.topLeftY, {N{PW'(1)}});

`ifdef PARALLAX_EN
      do_reset();
      for (int i = 0; i < N; i++) begin ix[i] = 100; iy[i] = 100; end
      do_load('1);
      bus.parallaxShift = '0;
      bus.parallaxShift[2:0] = 3'd1;
      run_frame(0, 64, -1, 0, 0, -1);
      run_frame(0, 64, -1, 0, 0, -1);
      check("plx_y0", ty(0), 101);
      check("plx_y1", ty(1), 102);
      bus.parallaxShift = '0;
`endif

      // Random frames against the modulo model.
      do_reset();
      for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; end
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(1) == 1) begin
            lm = N'($urandom);
            for (int i = 0; i < N; i++) begin
               ix[i] = int'($urandom_range(639));
               iy[i] = int'($urandom_range(479));
               if (lm[i]) begin mx[i] = ix[i] * 64; my[i] = iy[i] * 64; end
            end
            do_load(lm);
         end
         vis = N'($urandom);
         bus.visible = vis;
         sx = int'($urandom_range(40000)) - 20000;
         sy = int'($urandom_range(40000)) - 20000;
         run_frame(sx, sy, -1, 0, 0, -1);
         em = '0;
         for (int i = 0; i < N; i++) begin
            if (vis[i]) begin
               n = mx[i] + sx;
               if (n < 0 || n >= SPX) em[i] = 1'b1;
               mx[i] = ((n % SPX) + SPX) % SPX;
               n = my[i] + sy;
               if (n < 0 || n >= SPY) em[i] = 1'b1;
               my[i] = ((n % SPY) + SPY) % SPY;
            end
            ex[i*PW +: PW] = PW'(mx[i] / 64);
            ey[i*PW +: PW] = PW'(my[i] / 64);
         end
         check($sformatf("rand%0d_x", f), bus.topLeftX, ex);
         check($sformatf("rand%0d_y", f), bus.topLeftY, ey);
         check($sformatf("rand%0d_wrap", f), wmask, em);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
